// File: rtl/mux_vc_id_arb_if.sv
// Bundle of the two VC FIFO read ports, downstream stall, merged output and debug counters.
// slave is the arbiter's view; master is the view of whatever drives the FIFOs and sinks the output.
interface mux_vc_id_arb_if #(
   parameter int BW = 6
);
   logic [BW-1:0] vc0_data;
   logic          vc0_empty;
   logic          vc0_pop;
   logic [BW-1:0] vc1_data;
   logic          vc1_empty;
   logic          vc1_pop;
   logic          out_stall;
   logic [BW-1:0] mux_vcid_out;
   logic          mux_vcid_valid_out;
   logic [7:0]    sent_vc0_cnt;
   logic [7:0]    sent_vc1_cnt;
   logic          vc_err;

   modport slave (
      input  vc0_data, vc0_empty, vc1_data, vc1_empty, out_stall,
      output vc0_pop, vc1_pop, mux_vcid_out, mux_vcid_valid_out,
             sent_vc0_cnt, sent_vc1_cnt, vc_err
   );

   modport master (
      output vc0_data, vc0_empty, vc1_data, vc1_empty, out_stall,
      input  vc0_pop, vc1_pop, mux_vcid_out, mux_vcid_valid_out,
             sent_vc0_cnt, sent_vc1_cnt, vc_err
   );
endinterface

// File: rtl/mux_vc_id_arb.sv
// Merges the VC0/VC1 show-ahead FIFO heads into one registered data/valid stream.
// Define ARB_WEIGHTED_EN for weighted round-robin; the default build is strict VC0 priority.
module mux_vc_id_arb #(
   parameter int BW     = 6,
   parameter int VC_BIT = 5,
   parameter int WEIGHT = 4
) (
   input logic            clk,
   input logic            reset_L,
   mux_vc_id_arb_if.slave bus
);
   localparam logic [3:0] WEIGHT_C = WEIGHT[3:0];

   logic          grant0_s;
   logic          grant1_s;
   logic [3:0]    wcnt_q;
   logic [3:0]    wcnt_d;
   logic [BW-1:0] out_q;
   logic [BW-1:0] out_d;
   logic          valid_q;
   logic          valid_d;
   logic [7:0]    cnt0_q;
   logic [7:0]    cnt0_d;
   logic [7:0]    cnt1_q;
   logic [7:0]    cnt1_d;
   logic          err_q;
   logic          err_d;

   // Strict priority keeps wcnt at zero, so the VC1 turn never comes while VC0 has data.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset_L && !bus.out_stall) begin
         case ({bus.vc0_empty, bus.vc1_empty})
            2'b01: grant0_s = 1'b1;
            2'b10: grant1_s = 1'b1;
            2'b00: begin
               if (wcnt_q < WEIGHT_C) begin
                  grant0_s = 1'b1;
               end else begin
                  grant1_s = 1'b1;
               end
            end
            default: begin
               grant0_s = 1'b0;
               grant1_s = 1'b0;
            end
         endcase
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

`ifdef ARB_WEIGHTED_EN
   // Counts consecutive VC0 wins while VC1 is waiting; stalls freeze it.
   always_comb begin
      wcnt_d = wcnt_q;
      if (bus.out_stall) begin
         wcnt_d = wcnt_q;
      end else if (bus.vc1_empty || grant1_s) begin
         wcnt_d = 4'd0;
      end else if (grant0_s) begin
         wcnt_d = wcnt_q + 4'd1;
      end else begin
         wcnt_d = wcnt_q;
      end
   end
`else
   always_comb begin
      wcnt_d = 4'd0;
   end
`endif

   always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      err_d   = err_q;
      if (grant0_s) begin
         out_d   = bus.vc0_data;
         valid_d = 1'b1;
         cnt0_d  = cnt0_q + 8'd1;
         err_d   = err_q | bus.vc0_data[VC_BIT];
      end else if (grant1_s) begin
         out_d   = bus.vc1_data;
         valid_d = 1'b1;
         cnt1_d  = cnt1_q + 8'd1;
         err_d   = err_q | ~bus.vc1_data[VC_BIT];
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         out_q   <= {BW{1'b0}};
         valid_q <= 1'b0;
         cnt0_q  <= 8'd0;
         cnt1_q  <= 8'd0;
         err_q   <= 1'b0;
         wcnt_q  <= 4'd0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         err_q   <= err_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign bus.vc0_pop            = grant0_s;
   assign bus.vc1_pop            = grant1_s;
   assign bus.mux_vcid_out       = out_q;
   assign bus.mux_vcid_valid_out = valid_q;
   assign bus.sent_vc0_cnt       = cnt0_q;
   assign bus.sent_vc1_cnt       = cnt1_q;
   assign bus.vc_err             = err_q;
endmodule

// File: doc/mux_vc_id_arb.md
# mux_vc_id_arb

Two-input virtual-channel arbiter/multiplexer that merges the VC0 and VC1 FIFO outputs back into a single stream. It is the transmit-side counterpart of the VC-ID demux. It pops show-ahead FIFOs under downstream backpressure and drives one registered data/valid pair. Per-VC word counters and a sticky VC-tag error flag are maintained for debug and verification.

## Interface
Parameters:
- BW, 6, word width; must be greater than VC_BIT.
- VC_BIT, 5, bit index carrying the VC tag (0 = VC0, 1 = VC1).
- WEIGHT, 4, maximum consecutive VC0 grants while VC1 waits; range 1..15. Used only when ARB_WEIGHTED_EN is defined.

Ports (single clock; reset synchronous, active-low):
- clk, input, 1, clock; all state updates on the rising edge.
- reset_L, input, 1, synchronous active-low reset.
- vc0_data, input, BW, VC0 FIFO head word (show-ahead, valid while vc0_empty=0).
- vc0_empty, input, 1, VC0 FIFO empty.
- vc0_pop, output, 1, VC0 FIFO pop; combinational.
- vc1_data, input, BW, VC1 FIFO head word.
- vc1_empty, input, 1, VC1 FIFO empty.
- vc1_pop, output, 1, VC1 FIFO pop; combinational.
- out_stall, input, 1, downstream almost-full; blocks all pops.
- mux_vcid_out, output, BW, merged data; registered.
- mux_vcid_valid_out, output, 1, merged valid; registered.
- sent_vc0_cnt, output, 8, VC0 words forwarded, wrapping.
- sent_vc1_cnt, output, 8, VC1 words forwarded, wrapping.
- vc_err, output, 1, sticky error: a popped word's tag bit does not match its source VC.

## Operation
Grant decision is combinational each cycle. A pop occurs only when reset_L=1 and out_stall=0.
- Stalled, or both FIFOs empty: no pop.
- Only VC0 non-empty: grant VC0.
- Only VC1 non-empty: grant VC1.
- Both non-empty: grant per the arbitration mode (see Configuration).
- At most one pop per cycle. vc0_pop and vc1_pop are never both 1.

On a granted pop:
- The granted data is registered into mux_vcid_out and mux_vcid_valid_out is set to 1 on the same edge.
- The matching sent counter increments; 8'hFF wraps to 8'h00.
- vc_err is set if the VC0 pop has vc0_data[VC_BIT]=1, or the VC1 pop has vc1_data[VC_BIT]=0. It stays set until reset.

With no pop:
- mux_vcid_valid_out is 0 on the next edge.
- mux_vcid_out holds its last value.
- Counters and weight state hold.

## Timing
- Reset (reset_L=0 at an edge): mux_vcid_out=0, mux_vcid_valid_out=0, both counters=0, vc_err=0, weight counter=0.
- vc0_pop and vc1_pop are forced to 0 combinationally while reset_L=0.
- Latency: pop in cycle N gives data/valid on mux_vcid_out in cycle N+1. Back-to-back pops give a continuous valid stream.
- out_stall is sampled combinationally in the same cycle. Stall asserted in cycle N means no pop in N and valid=0 in N+1. No word is lost or duplicated.
- Reset released mid-stream: the first pop may occur in the first cycle with reset_L=1.
- Reset asserted mid-stream: pops stop immediately, and the in-flight output is cleared at the next edge.
- FIFO going empty in the same cycle as its last pop: no special handling; the next cycle re-evaluates the empty flags.

## Configuration
Macro ARB_WEIGHTED_EN selects the arbitration mode when both FIFOs are non-empty.

Without ARB_WEIGHTED_EN (strict priority):
- VC0 always wins; VC1 is served only when VC0 is empty.

With ARB_WEIGHTED_EN (weighted round-robin), using a 4-bit weight counter wcnt:
- Both non-empty and wcnt<WEIGHT: grant VC0, wcnt increments.
- Both non-empty and wcnt==WEIGHT: grant VC1, wcnt clears to 0.
- Any VC1 grant clears wcnt.
- A cycle with vc1_empty=1 clears wcnt.
- A stall cycle holds wcnt.

## Test plan
- Reset: hold reset_L=0 for 3 cycles with both FIFOs non-empty -> no pops; all outputs 0.
- Single VC1: VC1 holds 6'h21, 6'h22, 6'h23; VC0 empty -> three consecutive vc1_pop; output 21,22,23 with valid one cycle after each pop; sent_vc1_cnt=3; vc_err=0.
- Strict priority (macro off): 5 words in each FIFO -> 5 VC0 words, then 5 VC1 words, valid continuous for 10 cycles.
- Weighted (macro on, WEIGHT=4): 10 words in each FIFO -> grant order 0,0,0,0,1,0,0,0,0,1,...
- Stall: assert out_stall for 2 cycles mid-stream -> no pops and valid=0 for 2 cycles; the output sequence resumes with no loss or duplication.
- Tag error and wrap: VC0 word 6'h25 -> vc_err=1 and stays set; 256 VC0 pops -> sent_vc0_cnt wraps to 0.
